// File: rtl/la_hstx.sv
// -----------------------------------------------------------------------------
// la_hstx : source-domain launcher of a 4-phase req/ack clock-domain crossing.
//
// Takes one word from a valid/ready port, holds it on tx_data, raises tx_req
// and waits for the far end to acknowledge. The returning tx_ack is brought
// into the clk domain through an internal flop chain (ack_s); every handshake
// decision looks at ack_s only. The return-to-zero phase completes before the
// next word is taken, so throughput is one word per full round trip.
//
// Parameters
//   DW       data width
//   STAGES   tx_ack synchronizer depth (>= 2)
//   TIMEOUT  cycles without handshake progress before err is set (0 = off)
//
// Ports
//   clk       in   source-domain clock
//   reset     in   asynchronous active-high reset
//   in_valid  in   in_data valid
//   in_ready  out  word is taken this cycle if in_valid is high
//   in_data   in   word to transfer
//   tx_req    out  registered request to the far domain
//   tx_data   out  registered word, held from acceptance until the next one
//   tx_ack    in   acknowledge from the far domain (asynchronous)
//   busy      out  a transfer is in flight
//   err       out  sticky handshake timeout flag
// -----------------------------------------------------------------------------
module la_hstx #(
   parameter int DW      = 8,
   parameter int STAGES  = 2,
   parameter int TIMEOUT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          tx_req,
   output logic [DW-1:0] tx_data,
   input  logic          tx_ack,
   output logic          busy,
   output logic          err
);

   localparam int            TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [STAGES-1:0] ack_sync;
   logic [STAGES-1:0] prime_sr;
   logic              ack_s;
   logic              primed;
   logic              can_take;
   logic              accept;
   logic [TW-1:0]     tcnt;
   logic [TW-1:0]     tcnt_nxt;

   // Saturating increment of the progress counter.
   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
      if (v >= TMAX) begin
         return TMAX;
      end
      return v + TW'(1);
   endfunction

   // tx_ack synchronizer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[STAGES-2:0], tx_ack};
      end
   end

   assign ack_s = ack_sync[STAGES-1];

   // The synchronizer comes out of reset holding 0 regardless of tx_ack.
   // prime_sr fills with ones over the same STAGES edges, so until it is full
   // ack_s is not yet a real sample of tx_ack and no word may be taken. This
   // keeps a far end that still holds tx_ack=1 across reset from being read
   // as idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_sr <= '0;
      end else begin
         prime_sr <= {prime_sr[STAGES-2:0], 1'b1};
      end
   end

   assign primed   = prime_sr[STAGES-1];
   assign can_take = primed & ~ack_s;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = can_take;
            if (in_valid && can_take) begin
               accept    = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               state_nxt = REL;
            end
         end
         REL: begin
            if (!ack_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // Progress counter restarts on every state change and only runs while a
   // transfer waits on the far end.
   always_comb begin
      tcnt_nxt = '0;
      if ((state_nxt == state) && (state != IDLE)) begin
         tcnt_nxt = sat_inc(tcnt);
      end
   end

   // Request / data / timeout registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_req  <= 1'b0;
         tx_data <= '0;
         tcnt    <= '0;
         err     <= 1'b0;
      end else begin
         tcnt <= tcnt_nxt;
         if (accept) begin
            tx_data <= in_data;
            tx_req  <= 1'b1;
         end else if ((state == REQ) && ack_s) begin
            tx_req <= 1'b0;
         end
         // err rises on the same edge the counter reaches TIMEOUT and then
         // stays set; the handshake itself keeps waiting.
         if ((TIMEOUT != 0) && (tcnt_nxt == TMAX)) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_la_hstx.sv
`timescale 1ns/1ps
module tb_la_hstx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        in_valid_a, in_ready_a, tx_req_a, tx_ack_a, busy_a, err_a;
   logic [7:0]  in_data_a, tx_data_a;
   logic        in_valid_b, in_ready_b, tx_req_b, tx_ack_b, busy_b, err_b;
   logic [31:0] in_data_b, tx_data_b;

   la_hstx #(.DW(8), .STAGES(2), .TIMEOUT(10)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_data(in_data_a), .tx_req(tx_req_a), .tx_data(tx_data_a),
      .tx_ack(tx_ack_a), .busy(busy_a), .err(err_a));

   la_hstx #(.DW(32), .STAGES(3), .TIMEOUT(0)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_data(in_data_b), .tx_req(tx_req_b), .tx_data(tx_data_b),
      .tx_ack(tx_ack_b), .busy(busy_b), .err(err_b));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0]  exp_q_a[$];
   logic [31:0] exp_q_b[$];
   int          rx_cnt_a = 0;
   int          rx_cnt_b = 0;

   // Far end A: echo of tx_req three clocks late, or a forced level.
   logic       ack_mode = 1'b0;
   logic       ack_force = 1'b0;
   logic [3:0] hist_a = '0;
   logic       ack_nxt_a;
   initial begin
      tx_ack_a = 1'b0;
      forever begin
         @(negedge clk);
         hist_a    = {hist_a[2:0], tx_req_a};
         ack_nxt_a = ack_mode ? ack_force : hist_a[3];
         if (ack_nxt_a && !tx_ack_a && tx_req_a) begin
            rx_cnt_a++;
            check("a_rx_pending", 32'(exp_q_a.size() > 0), 32'd1);
            if (exp_q_a.size() > 0) check("a_rx_data", 32'(tx_data_a), 32'(exp_q_a.pop_front()));
         end
         tx_ack_a = ack_nxt_a;
      end
   end

   // Far end B: random 1..20 clock response on both phases.
   int   fe_b = 0;
   int   wait_b = 0;
   int   ack_low_b = 100;
   logic req_prev_b = 1'b0;
   initial begin
      tx_ack_b = 1'b0;
      forever begin
         @(negedge clk);
         // With STAGES=3 the earliest new request comes 5 clocks after ack fell.
         if (tx_req_b && !req_prev_b) check("b_req_rise_ack_low", 32'(ack_low_b >= 5), 32'd1);
         req_prev_b = tx_req_b;
         case (fe_b)
            0: if (tx_req_b) begin wait_b = $urandom_range(1, 20); fe_b = 1; end
            1: if (wait_b > 1) wait_b--;
               else begin
                  rx_cnt_b++;
                  check("b_rx_pending", 32'(exp_q_b.size() > 0), 32'd1);
                  if (exp_q_b.size() > 0) check("b_rx_data", tx_data_b, exp_q_b.pop_front());
                  tx_ack_b = 1'b1;
                  fe_b = 2;
               end
            2: if (!tx_req_b) begin wait_b = $urandom_range(1, 20); fe_b = 3; end
            default: if (wait_b > 1) wait_b--;
               else begin tx_ack_b = 1'b0; fe_b = 0; end
         endcase
         if (tx_ack_b) ack_low_b = 0;
         else if (ack_low_b < 100) ack_low_b++;
      end
   end

   // tx_data must not move while a transfer is in flight.
   logic        bp_a = 1'b0, bp_b = 1'b0;
   logic [7:0]  dp_a = '0;
   logic [31:0] dp_b = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (busy_a && bp_a) check("a_data_hold", 32'(tx_data_a), 32'(dp_a));
         if (busy_b && bp_b) check("b_data_hold", tx_data_b, dp_b);
         bp_a = busy_a; dp_a = tx_data_a;
         bp_b = busy_b; dp_b = tx_data_b;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] d);
      int n = 0;
      in_data_a  = d;
      in_valid_a = 1'b1;
      while (!in_ready_a && n < 300) begin cyc(); n++; end
      check("a_send_ready", 32'(in_ready_a), 32'd1);
      if (in_ready_a) begin
         @(posedge clk);
         exp_q_a.push_back(d);
         #1;
      end
   endtask

   task automatic send_b(input logic [31:0] d);
      int n = 0;
      in_data_b  = d;
      in_valid_b = 1'b1;
      while (!in_ready_b && n < 300) begin cyc(); n++; end
      check("b_send_ready", 32'(in_ready_b), 32'd1);
      if (in_ready_b) begin
         @(posedge clk);
         exp_q_b.push_back(d);
         #1;
      end
   endtask

   task automatic drain_a(input string tag);
      int n = 0;
      while ((exp_q_a.size() != 0 || busy_a) && n < 1000) begin cyc(); n++; end
      check(tag, 32'(n < 1000), 32'd1);
   endtask

   task automatic drain_b(input string tag);
      int n = 0;
      while ((exp_q_b.size() != 0 || busy_b) && n < 3000) begin cyc(); n++; end
      check(tag, 32'(n < 3000), 32'd1);
   endtask

   int n;
   int base;

   initial begin
      reset = 1'b1;
      in_valid_a = 1'b0; in_data_a = '0;
      in_valid_b = 1'b0; in_data_b = '0;
      repeat (3) cyc();
      check("rst_tx_req",   32'(tx_req_a),   32'd0);
      check("rst_tx_data",  32'(tx_data_a),  32'd0);
      check("rst_busy",     32'(busy_a),     32'd0);
      check("rst_err",      32'(err_a),      32'd0);
      check("rst_in_ready", 32'(in_ready_a), 32'd0);
      check("rst_b_ready",  32'(in_ready_b), 32'd0);
      reset = 1'b0;
      repeat (5) cyc();

      // Basic transfer and latency
      send_a(8'hA5);
      in_valid_a = 1'b0;
      check("t1_req",   32'(tx_req_a),   32'd1);
      check("t1_data",  32'(tx_data_a),  32'hA5);
      check("t1_busy",  32'(busy_a),     32'd1);
      check("t1_ready", 32'(in_ready_a), 32'd0);
      n = 0;
      while (tx_req_a && n < 100) begin cyc(); n++; end
      check("t1_req_fall_lat", n, 6);
      n = 0;
      while (!in_ready_a && n < 100) begin cyc(); n++; end
      check("t1_ready_lat", n, 6);
      repeat (10) cyc();
      check("t1_one_xfer", rx_cnt_a, 1);

      // Stream of 16 words with in_valid held high
      base = rx_cnt_a;
      for (int i = 0; i < 16; i++) send_a(8'(i));
      in_valid_a = 1'b0;
      drain_a("t2_drain");
      check("t2_count", rx_cnt_a - base, 16);

      // Timeout with ack held low
      ack_mode = 1'b1; ack_force = 1'b0;
      send_a(8'h99);
      in_valid_a = 1'b0;
      repeat (9) cyc();
      check("t5_err_early", 32'(err_a), 32'd0);
      cyc();
      check("t5_err_set",  32'(err_a),  32'd1);
      check("t5_req_held", 32'(tx_req_a), 32'd1);
      repeat (5) cyc();
      check("t5_still_req", 32'(tx_req_a), 32'd1);
      ack_force = 1'b1;
      n = 0;
      while (tx_req_a && n < 100) begin cyc(); n++; end
      check("t5_req_fall", 32'(tx_req_a), 32'd0);
      ack_force = 1'b0;
      drain_a("t5_drain");
      check("t5_err_sticky", 32'(err_a), 32'd1);

      // Reset in the middle of REQ
      send_a(8'h77);
      in_valid_a = 1'b0;
      cyc();
      check("t4_req_before", 32'(tx_req_a), 32'd1);
      reset = 1'b1;
      #1;
      check("t4_req_async",  32'(tx_req_a), 32'd0);
      check("t4_busy_async", 32'(busy_a),   32'd0);
      check("t4_err_async",  32'(err_a),    32'd0);
      exp_q_a.delete();
      cyc();
      reset = 1'b0;
      repeat (6) cyc();
      ack_mode = 1'b0;
      base = rx_cnt_a;
      send_a(8'h5A);
      in_valid_a = 1'b0;
      check("t4_req_next", 32'(tx_req_a), 32'd1);
      drain_a("t4_drain");
      check("t4_count", rx_cnt_a - base, 1);

      // Stale acknowledge held through reset release
      ack_mode = 1'b1; ack_force = 1'b1;
      repeat (4) cyc();
      check("t3_ready_idle_ack", 32'(in_ready_a), 32'd0);
      reset = 1'b1;
      repeat (3) cyc();
      reset = 1'b0;
      in_data_a  = 8'h3C;
      in_valid_a = 1'b1;
      #1;
      check("t3_ready_release", 32'(in_ready_a), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         check("t3_ready_stale", 32'(in_ready_a), 32'd0);
         check("t3_req_stale",   32'(tx_req_a),   32'd0);
      end
      ack_force = 1'b0; ack_mode = 1'b0;
      cyc();
      check("t3_ready_e1", 32'(in_ready_a), 32'd0);
      cyc();
      check("t3_ready_e2", 32'(in_ready_a), 32'd1);
      base = rx_cnt_a;
      send_a(8'h3C);
      in_valid_a = 1'b0;
      check("t3_data", 32'(tx_data_a), 32'h3C);
      drain_a("t3_drain");
      check("t3_count", rx_cnt_a - base, 1);

      // Random far-end delays, random in_valid, DW=32 STAGES=3
      base = rx_cnt_b;
      for (int i = 0; i < 40; i++) begin
         in_valid_b = 1'b0;
         in_data_b  = $urandom;
         repeat ($urandom_range(0, 3)) cyc();
         send_b($urandom);
      end
      in_valid_b = 1'b0;
      drain_b("t6_drain");
      check("t6_count", rx_cnt_b - base, 40);
      check("t6_err",   32'(err_b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
